// File: rtl/pbit_sweep_scheduler.sv
// pbit_sweep_scheduler
// Sequential Gibbs-sampling controller sharing one external p-bit across an
// N-spin Ising network. Holds J (N x N), h (N) and the spin vector; for each
// spin in order 0..N-1 it accumulates the local field, negates and saturates
// it onto pb_input_val, waits PB_LAT cycles and writes pb_out back as the spin.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   start             one-cycle run request (accepted only in IDLE)
//   num_sweeps        sweeps per run, latched on accepted start
//   beta_shift        inverse-temperature code, latched on start -> pb_bit_shift
//   cfg_we/row/col/data  host writes: col<N -> J[row][col], col==N -> h[row],
//                     col==N+1 -> spins[row]=data[0]; ignored while busy
//   pb_input_val      signed 4-bit clamp(-field) to the p-bit
//   pb_bit_shift      latched beta_shift
//   pb_out            p-bit sample, taken in WRITE
//   busy, done        run status; done is a one-cycle pulse
//   spins             spin state (1 = +1, 0 = -1)
//   sweep_cnt         sweeps completed in current/last run
module pbit_sweep_scheduler #(
    parameter int N      = 8,
    parameter int ACC_W  = 8,
    parameter int PB_LAT = 2,
    localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          num_sweeps,
    input  logic [1:0]          beta_shift,
    input  logic                cfg_we,
    input  logic [IW-1:0]       cfg_row,
    input  logic [IW:0]         cfg_col,
    input  logic signed [3:0]   cfg_data,
    output logic signed [3:0]   pb_input_val,
    output logic [1:0]          pb_bit_shift,
    input  logic                pb_out,
    output logic                busy,
    output logic                done,
    output logic [N-1:0]        spins,
    output logic [7:0]          sweep_cnt
);
    localparam int WW = $clog2(PB_LAT + 1);
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(7);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-8);

    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_SAT, S_WAIT, S_WRITE, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [3:0]       j_mem [N][N];
    logic signed [3:0]       h_mem [N];
    logic [IW-1:0]           i_idx, j_idx;
    logic [7:0]              target;
    logic [WW-1:0]           wcnt;
    logic signed [ACC_W-1:0] acc, acc_sum, base, wsel, term, neg_acc;
    logic signed [3:0]       sat;
    logic                    cfg_ok;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (num_sweeps == 8'd0) ? S_DONE : S_ACCUM;
            end
            S_ACCUM: begin
                busy = 1'b1;
                if (j_idx == LAST) state_nxt = S_SAT;
            end
            S_SAT: begin
                busy      = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (wcnt == WW'(PB_LAT - 1)) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                if (i_idx == LAST && (sweep_cnt + 8'd1) == target)
                    state_nxt = S_DONE;
                else
                    state_nxt = S_ACCUM;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Field accumulation. The bias is folded in on the j==0 cycle instead of
    // preloading acc on ACCUM entry, so a cfg write landing on the same edge
    // as start is already visible to the first update.
    always_comb begin
        wsel    = ACC_W'(j_mem[i_idx][j_idx]);
        base    = (j_idx == '0) ? ACC_W'(h_mem[i_idx]) : acc;
        if (j_idx == i_idx)      term = '0;
        else if (spins[j_idx])   term = wsel;
        else                     term = -wsel;
        acc_sum = base + term;
        neg_acc = -acc;
        if (neg_acc > SAT_HI)      sat = 4'sd7;
        else if (neg_acc < SAT_LO) sat = 4'sb1000;
        else                       sat = neg_acc[3:0];
    end

    assign cfg_ok = cfg_we && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < N; r++) begin
                h_mem[r] <= '0;
                for (int unsigned c = 0; c < N; c++) j_mem[r][c] <= '0;
            end
            spins        <= '0;
            sweep_cnt    <= '0;
            pb_input_val <= '0;
            pb_bit_shift <= '0;
            target       <= '0;
            i_idx        <= '0;
            j_idx        <= '0;
            wcnt         <= '0;
            acc          <= '0;
        end else begin
            if (cfg_ok && int'(cfg_row) < N) begin
                if (int'(cfg_col) < N)        j_mem[cfg_row][cfg_col[IW-1:0]] <= cfg_data;
                else if (int'(cfg_col) == N)  h_mem[cfg_row] <= cfg_data;
                else if (int'(cfg_col) == N+1) spins[cfg_row] <= cfg_data[0];
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        target       <= num_sweeps;
                        pb_bit_shift <= beta_shift;
                        i_idx        <= '0;
                        j_idx        <= '0;
                        sweep_cnt    <= '0;
                    end
                end
                S_ACCUM: begin
                    acc   <= acc_sum;
                    j_idx <= (j_idx == LAST) ? '0 : j_idx + 1'b1;
                end
                S_SAT: begin
                    pb_input_val <= sat;
                    wcnt         <= '0;
                end
                S_WAIT: wcnt <= wcnt + 1'b1;
                S_WRITE: begin
                    spins[i_idx] <= pb_out;
                    j_idx        <= '0;
                    if (i_idx == LAST) begin
                        i_idx     <= '0;
                        sweep_cnt <= sweep_cnt + 8'd1;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pbit_sweep_scheduler.sv
// Testbench for pbit_sweep_scheduler: directed runs with hand-computed
// expectations pushed into scoreboard queues; a monitor pops and compares at
// each p-bit sample point and at each done pulse.
module tb_pbit_sweep_scheduler;
    localparam int N      = 8;
    localparam int PB_LAT = 2;
    localparam int T      = N + PB_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        num_sweeps = '0;
    logic [1:0]        beta_shift = '0;
    logic              cfg_we = 1'b0;
    logic [2:0]        cfg_row = '0;
    logic [3:0]        cfg_col = '0;
    logic signed [3:0] cfg_data = '0;
    logic signed [3:0] pb_input_val;
    logic [1:0]        pb_bit_shift;
    logic              pb_out = 1'b0;
    logic              busy, done;
    logic [N-1:0]      spins;
    logic [7:0]        sweep_cnt;

    pbit_sweep_scheduler #(.N(N), .ACC_W(8), .PB_LAT(PB_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .num_sweeps(num_sweeps),
        .beta_shift(beta_shift), .cfg_we(cfg_we), .cfg_row(cfg_row),
        .cfg_col(cfg_col), .cfg_data(cfg_data), .pb_input_val(pb_input_val),
        .pb_bit_shift(pb_bit_shift), .pb_out(pb_out), .busy(busy), .done(done),
        .spins(spins), .sweep_cnt(sweep_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [3:0] pb;
        logic [7:0]        sw;
        logic [1:0]        sh;
    } upd_t;

    typedef struct {
        int          len;
        logic [7:0]  sp;
        logic [7:0]  cnt;
        logic [1:0]  sh;
    } run_t;

    upd_t upd_q[$];
    run_t run_q[$];
    logic signed [3:0] pbt [N];

    int total = 0;
    int bad   = 0;
    int bcnt  = 0;

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Expected response of one run: per-update pb value (pbt repeats each
    // sweep), completed-sweep count at sample time, and the final summary.
    task automatic push_run(input int s, input logic [1:0] sh, input logic [7:0] fs);
        upd_t u;
        run_t r;
        for (int k = 0; k < s * N; k++) begin
            u.pb = pbt[k % N];
            u.sw = 8'(k / N);
            u.sh = sh;
            upd_q.push_back(u);
        end
        r.len = s * N * T;
        r.sp  = fs;
        r.cnt = 8'(s);
        r.sh  = sh;
        run_q.push_back(r);
    endtask

    // Monitor
    always @(negedge clk) begin
        upd_t u;
        run_t r;
        if (reset) begin
            bcnt = 0;
        end else begin
            if (busy) begin
                bcnt++;
                if (((bcnt - 1) % T) == N + 1 && upd_q.size() > 0) begin
                    u = upd_q.pop_front();
                    chk("pb_input_val", int'(pb_input_val), int'(u.pb));
                    chk("sweep_cnt_mid", int'(sweep_cnt), int'(u.sw));
                    chk("pb_bit_shift", int'(pb_bit_shift), int'(u.sh));
                end
            end
            if (done) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    r = run_q.pop_front();
                    chk("busy_len", bcnt, r.len);
                    chk("final_spins", int'(spins), int'(r.sp));
                    chk("final_sweep_cnt", int'(sweep_cnt), int'(r.cnt));
                    chk("final_shift", int'(pb_bit_shift), int'(r.sh));
                end
                bcnt = 0;
            end else if (!busy) begin
                bcnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic cfg(input int r, input int c, input int d);
        cfg_we   = 1'b1;
        cfg_row  = 3'(r);
        cfg_col  = 4'(c);
        cfg_data = 4'(d);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic start_run(input int s, input logic [1:0] sh);
        start      = 1'b1;
        num_sweeps = 8'(s);
        beta_shift = sh;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int seen = 0;
        for (int k = 0; k < budget && seen == 0; k++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        chk("run_completes", seen, 1);
        @(negedge clk);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_spins"}, int'(spins), 0);
        chk({tag, "_sweep_cnt"}, int'(sweep_cnt), 0);
        chk({tag, "_pb_val"}, int'(pb_input_val), 0);
        chk({tag, "_pb_shift"}, int'(pb_bit_shift), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        tick(3);
        check_cleared("por");
        reset = 1'b0;
        tick(1);

        // Zero network, one sweep, pb_out=1 -> 96 busy cycles, all pb 0
        pbt = '{default: 4'sd0};
        pb_out = 1'b1;
        push_run(1, 2'b00, 8'hFF);
        start_run(1, 2'b00);
        wait_done(200);

        // Reset in IDLE clears spins and counters
        reset = 1'b1;
        tick(2);
        check_cleared("idle_rst");
        reset = 1'b0;
        tick(1);

        // Field arithmetic: J[1][0]=3, J[1][2]=-2, h[1]=1
        cfg(1, 0, 3);
        cfg(1, 2, -2);
        cfg(1, N, 1);
        pbt = '{4'sd0, -4'sd6, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0};
        push_run(1, 2'b00, 8'hFF);
        start_run(1, 2'b00);
        wait_done(200);

        // Reset asserted during WAIT of the first update: no done, all cleared
        start_run(2, 2'b11);
        tick(9);
        reset = 1'b1;
        tick(2);
        check_cleared("wait_rst");
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) chk("no_done_after_reset", 1, 0);
        end
        chk("idle_after_reset", int'(busy), 0);

        // Ignore rules: start and cfg writes mid-run have no effect
        pb_out = 1'b0;
        pbt = '{default: 4'sd0};
        push_run(1, 2'b00, 8'h00);
        start_run(1, 2'b00);
        tick(30);
        cfg(3, N, 5);
        cfg(5, 0, -7);
        cfg(7, N + 1, 1);
        start_run(5, 2'b11);
        wait_done(200);
        push_run(1, 2'b00, 8'h00);
        start_run(1, 2'b00);
        wait_done(200);

        // num_sweeps=0: done next cycle, spins untouched, shift latched
        cfg(2, N + 1, 1);
        cfg(5, N + 1, 1);
        push_run(0, 2'b01, 8'h24);
        start_run(0, 2'b01);
        wait_done(5);

        // Saturation: all J=h=+7, spins all 1, pb_out=0.
        // Field at update i is 56-14i -> pb = clamp(14i-56).
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                if (!(r == 4 && c == 3)) cfg(r, c, 7);
        for (int r = 0; r < N; r++) cfg(r, N, 7);
        for (int r = 0; r < N; r++) cfg(r, N + 1, 1);
        pbt = '{4'sb1000, 4'sb1000, 4'sb1000, 4'sb1000, 4'sd0, 4'sd7, 4'sd7, 4'sd7};
        push_run(1, 2'b00, 8'h00);
        // J[4][3] lands on the same edge as start; update 4 depends on it
        cfg_we = 1'b1; cfg_row = 3'd4; cfg_col = 4'd3; cfg_data = 4'sd7;
        start_run(1, 2'b00);
        cfg_we = 1'b0;
        wait_done(200);

        // Multi-sweep on a cleared network
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        pb_out = 1'b1;
        pbt = '{default: 4'sd0};
        push_run(3, 2'b10, 8'hFF);
        start_run(3, 2'b10);
        wait_done(500);
        tick(5);

        chk("upd_queue_drained", upd_q.size(), 0);
        chk("run_queue_drained", run_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
